mul_div_seq: RTL and testbench
==============================

Name: mul_div_seq

Overview:
Parametrised multi-cycle integer multiply/divide sequencer. It supersedes the microcode expansion of multiply inside the single-cycle core. Execute hands it an operation through a valid/ready start handshake. It runs a radix-2^STEPS shift-add (multiply) or restoring shift-subtract (divide) loop, then returns the result, destination tag and NZCV flags through a valid/ready result handshake. Execute stalls fetch while busy is high.

Parameters:
DATA_W, 32, operand/result width; must be a multiple of STEPS.
STEPS, 1, iteration bits retired per clock; legal values 1, 2, 4.
TAG_W, 4, destination-register tag width.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
start_valid  in  1  operation offered
start_ready  out  1  sequencer can accept; high only in IDLE
mode  in  2  00 MUL (low half), 01 MULH (signed high half), 10 DIVU quotient, 11 REMU remainder
op_a  in  DATA_W  multiplicand / dividend
op_b  in  DATA_W  multiplier / divisor
tag_in  in  TAG_W  destination register index
abort  in  1  synchronous cancel (branch override / flush)
busy  out  1  high in RUN, FIX, DONE
result_valid  out  1  result held
result_ready  in  1  consumer takes result
result  out  DATA_W  operation result
tag_out  out  TAG_W  tag captured at accept
flags  out  4  [3]N [2]Z [1]C [0]V of result

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst. While rst=0: state=IDLE, start_ready=1, busy=0, result_valid=0, result/tag_out/flags=0, internal accumulators and counter=0.
- Accept: start_valid & start_ready & !abort at a rising edge. This latches mode, op_a, op_b, tag_in and clears the counter.
- FSM states:
  - IDLE: on accept, go to RUN. Exception: DIVU/REMU with op_b==0 goes to FIX.
  - RUN: performs STEPS iterations per edge. Counter increments per edge. After DATA_W/STEPS edges, go to FIX.
  - FIX: selects result, applies the MULH sign correction and computes flags. Next edge goes to DONE.
  - DONE: result_valid=1. On result_valid & result_ready, go to IDLE; start_ready rises the same edge.
- Latency: result_valid is high after edge DATA_W/STEPS+1, counting the accept edge as 0. That is 33 for the defaults. Divide by zero takes 1 edge.
- Back-to-back: a new start cannot be accepted in the same edge that the previous result is consumed. Minimum issue interval = latency+1.
- Multiply: DATA_W x DATA_W gives a 2*DATA_W unsigned product.
  - MULH takes absolute values of both operands and negates the 2*DATA_W product when the signs differ.
  - MUL returns the low half.
  - MULH returns the high half.
- Divide: unsigned restoring divide. DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: quotient = all ones, remainder = op_a.
- Flags:
  - N = result[DATA_W-1].
  - Z = (result==0).
  - C: for MUL, the high half of the unsigned product is nonzero. For DIVU/REMU, op_b==0. For MULH, 0.
  - V = 0.
- Result hold: result, tag_out and flags are stable from the first cycle of result_valid until the handshake completes. Back-pressure is unbounded.
- Abort:
  - In RUN, FIX or DONE: the next edge goes to IDLE and result_valid=0. The result is discarded; no partial result leaks.
  - In IDLE: blocks acceptance.
  - With start_valid at the same edge: abort wins and nothing is accepted.
- Reset mid-operation: immediate return to reset values. No result is produced after reset release.
- The counter width is clog2(DATA_W/STEPS)+1. There is no wrap-around because the counter is cleared at accept.

Decomposition:
- Shared package mul_div_pkg:
  - mode encodings MODE_MUL/MODE_MULH/MODE_DIVU/MODE_REMU
  - state encodings IDLE/RUN/FIX/DONE
  - flag bit indices FLAG_N/Z/C/V
- One combinational sub-module, mul_div_step. It performs one multiply or divide iteration on the {acc, shift register} pair and is instantiated STEPS times in a chain.

Test Plan:
1. Defaults. MUL op_a=7, op_b=6, tag_in=5 -> result=42, tag_out=5, flags=0000, result_valid at edge 33 after accept. start_ready=0 and busy=1 throughout.
2. MULH op_a=0xFFFFFFFE (-2), op_b=3 -> result=0xFFFFFFFF, flags N=1 Z=0. Also MUL 0x00010000*0x00010000 -> result=0, Z=1, C=1.
3. DIVU 100/7 -> result=14. REMU 100/7 -> result=2. Both at latency 33.
4. DIVU 5/0 -> result=0xFFFFFFFF, C=1, result_valid after edge 1. REMU 5/0 -> result=5, C=1.
5. Hold result_ready=0 for 10 cycles after result_valid -> result/tag/flags unchanged and start_ready stays 0. Then a ready pulse -> next edge IDLE, start_ready=1.
6. Abort asserted at RUN edge 10 -> IDLE next edge, result_valid never rises. Assert rst=0 asynchronously mid-RUN -> all outputs at reset values immediately. Rerun with STEPS=4 and check latency 9.

Source files
------------

// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared encodings for the multi-cycle multiply/divide sequencer.
//   mode_e  : operation select carried on the mode port
//   state_e : sequencer FSM states
//   FLAG_*  : bit positions inside the 4-bit NZCV flags output
package mul_div_pkg;

  typedef enum logic [1:0] {
    MODE_MUL  = 2'b00,
    MODE_MULH = 2'b01,
    MODE_DIVU = 2'b10,
    MODE_REMU = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/mul_div_step.sv
// mul_div_step: one combinational iteration on the {acc, shift register} pair.
//   is_div_i : 1 = restoring divide step, 0 = shift-add multiply step
//   opnd_i   : multiplicand (multiply) or divisor (divide)
//   acc_i/o  : high half of product / partial remainder
//   sr_i/o   : multiplier shifting out LSB-first, product low half shifting in
//              (multiply); dividend shifting out MSB-first, quotient shifting
//              in at the LSB (divide)
module mul_div_step #(
  parameter int DATA_W = 32
) (
  input  logic              is_div_i,
  input  logic [DATA_W-1:0] opnd_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] sr_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] sr_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] diff;
  logic              ge;

  always_comb begin
    sum     = {1'b0, acc_i} + (sr_i[0] ? {1'b0, opnd_i} : {(DATA_W+1){1'b0}});
    shifted = {acc_i[DATA_W-2:0], sr_i[DATA_W-1]};
    // The shifted remainder is DATA_W+1 bits wide; its top bit is acc_i MSB.
    // When that bit is set the value certainly exceeds the divisor, and the
    // modulo-2^DATA_W difference is still exact because the true result is
    // below the divisor.
    ge      = acc_i[DATA_W-1] | (shifted >= opnd_i);
    diff    = shifted - opnd_i;
    if (is_div_i) begin
      acc_o = ge ? diff : shifted;
      sr_o  = {sr_i[DATA_W-2:0], ge};
    end else begin
      acc_o = sum[DATA_W:1];
      sr_o  = {sum[0], sr_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_seq.sv
// mul_div_seq: multi-cycle integer multiply/divide sequencer.
//   clk, rst (async active-low)
//   start_valid/start_ready : operation handshake (ready only in IDLE)
//   mode, op_a, op_b, tag_in: operation, operands, destination tag
//   abort                   : synchronous cancel of any operation in flight
//   busy                    : high in RUN, FIX, DONE
//   result_valid/result_ready, result, tag_out, flags : result handshake
// Retires STEPS iteration bits per clock; latency DATA_W/STEPS+1 edges,
// divide by zero resolves in one edge.
module mul_div_seq
  import mul_div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEPS  = 1,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              abort,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  tag_out,
  output logic [3:0]        flags
);

  localparam int ITERS = DATA_W / STEPS;
  localparam int CNT_W = $clog2(ITERS) + 1;

  state_e              state_q;
  mode_e               mode_q;
  logic [DATA_W-1:0]   opnd_q, acc_q, sr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_q;
  logic [DATA_W-1:0]   result_q;
  logic [TAG_W-1:0]    tag_q;
  logic [3:0]          flags_q;
  logic                rvalid_q;

  logic [DATA_W-1:0]   acc_c [STEPS+1];
  logic [DATA_W-1:0]   sr_c  [STEPS+1];
  logic [DATA_W-1:0]   acc_d, sr_d;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   fix_res;
  logic                fix_c;
  logic [3:0]          fix_flags;

  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] n;
    n = -v;
    return v[DATA_W-1] ? $unsigned(n) : $unsigned(v);
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_prod(input logic [2*DATA_W-1:0] p);
    return (~p) + {{(2*DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // Iteration chain: STEPS bits retired per RUN edge
  assign acc_c[0] = acc_q;
  assign sr_c[0]  = sr_q;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    mul_div_step #(.DATA_W(DATA_W)) u_step (
      .is_div_i (mode_q[1]),
      .opnd_i   (opnd_q),
      .acc_i    (acc_c[g]),
      .sr_i     (sr_c[g]),
      .acc_o    (acc_c[g+1]),
      .sr_o     (sr_c[g+1])
    );
  end

  assign acc_d = acc_c[STEPS];
  assign sr_d  = sr_c[STEPS];

  // FIX stage: result select, MULH sign correction, flags
  always_comb begin
    prod    = {acc_q, sr_q};
    fix_res = sr_q;
    fix_c   = 1'b0;
    case (mode_q)
      MODE_MUL: begin
        fix_res = sr_q;
        fix_c   = |acc_q;
      end
      MODE_MULH: begin
        if (neg_q) prod = neg_prod({acc_q, sr_q});
        fix_res = prod[2*DATA_W-1:DATA_W];
      end
      MODE_DIVU: begin
        fix_res = (opnd_q == '0) ? '1 : sr_q;
        fix_c   = (opnd_q == '0);
      end
      MODE_REMU: begin
        // Divide by zero skips RUN, so sr_q still holds the dividend.
        fix_res = (opnd_q == '0) ? sr_q : acc_q;
        fix_c   = (opnd_q == '0);
      end
      default: ;
    endcase
    fix_flags         = 4'b0000;
    fix_flags[FLAG_N] = fix_res[DATA_W-1];
    fix_flags[FLAG_Z] = (fix_res == '0);
    fix_flags[FLAG_C] = fix_c;
    fix_flags[FLAG_V] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_MUL;
      opnd_q   <= '0;
      acc_q    <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
      flags_q  <= 4'b0000;
      rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid && !abort) begin
            mode_q <= mode_e'(mode);
            tag_q  <= tag_in;
            cnt_q  <= '0;
            acc_q  <= '0;
            if (mode_e'(mode) == MODE_MULH) begin
              opnd_q <= abs_val($signed(op_a));
              sr_q   <= abs_val($signed(op_b));
              neg_q  <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
            end else begin
              opnd_q <= mode[1] ? op_b : op_a;
              sr_q   <= mode[1] ? op_a : op_b;
              neg_q  <= 1'b0;
            end
            state_q <= (mode[1] && op_b == '0) ? FIX : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            sr_q  <= sr_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITERS - 1)) state_q <= FIX;
          end
        end
        FIX: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            result_q <= fix_res;
            flags_q  <= fix_flags;
            rvalid_q <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (abort || result_ready) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign result_valid = rvalid_q;
  assign result       = result_q;
  assign tag_out      = tag_q;
  assign flags        = flags_q;

endmodule

// File: tb/tb_mul_div_seq.sv
module tb_mul_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_valid = 1'b0, start_ready;
  logic [1:0]  mode = 2'b00;
  logic [31:0] op_a = '0, op_b = '0;
  logic [3:0]  tag_in = '0;
  logic        abort = 1'b0, busy, result_valid, result_ready = 1'b0;
  logic [31:0] result;
  logic [3:0]  tag_out, flags;

  logic        sv4 = 1'b0, sr4, abort4 = 1'b0, busy4, rv4, rr4 = 1'b0;
  logic [31:0] res4;
  logic [3:0]  tag4, flags4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_div_seq #(.DATA_W(32), .STEPS(1), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .mode(mode), .op_a(op_a), .op_b(op_b), .tag_in(tag_in), .abort(abort),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .tag_out(tag_out), .flags(flags)
  );

  mul_div_seq #(.DATA_W(32), .STEPS(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4),
    .mode(mode), .op_a(op_a), .op_b(op_b), .tag_in(tag_in), .abort(abort4),
    .busy(busy4), .result_valid(rv4), .result_ready(rr4),
    .result(res4), .tag_out(tag4), .flags(flags4)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the STEPS=1 instance, optionally stall the consumer for
  // 'hold' cycles, then consume. Called and returns at a negedge.
  task automatic run_op(input string nm, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] t, input int hold,
                        output logic [31:0] r, output logic [3:0] tg,
                        output logic [3:0] f, output int lat);
    logic hs_ok, stable;
    check_eq({nm, "_ready_before"}, start_ready, 1'b1);
    start_valid = 1'b1; mode = m; op_a = a; op_b = b; tag_in = t;
    @(negedge clk);
    start_valid = 1'b0;
    lat = 0; hs_ok = 1'b1;
    while (!result_valid && lat < 100) begin
      if (start_ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_eq({nm, "_busy_during"}, hs_ok, 1'b1);
    r = result; tg = tag_out; f = flags;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (result !== r || tag_out !== tg || flags !== f || result_valid !== 1'b1 ||
          start_ready !== 1'b0) stable = 1'b0;
    end
    check_eq({nm, "_hold_stable"}, stable, 1'b1);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check_eq({nm, "_ready_after"}, start_ready, 1'b1);
    check_eq({nm, "_valid_after"}, result_valid, 1'b0);
  endtask

  task automatic run_op4(input string nm, input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r, output int lat);
    sv4 = 1'b1; mode = m; op_a = a; op_b = b; tag_in = 4'h3;
    @(negedge clk);
    sv4 = 1'b0;
    lat = 0;
    while (!rv4 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = res4;
    rr4 = 1'b1;
    @(negedge clk);
    rr4 = 1'b0;
    check_eq({nm, "_ready_after"}, sr4, 1'b1);
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  tg, f;
    int          lat;
    logic        never;

    // Reset state while rst is low
    #12;
    check_eq("rst_start_ready", start_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_result_valid", result_valid, 1'b0);
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_tag_flags", {tag_out, flags}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // MUL 7*6, tag 5
    run_op("mul7x6", 2'b00, 32'd7, 32'd6, 4'd5, 0, r, tg, f, lat);
    check_eq("mul7x6_res", r, 32'd42);
    check_eq("mul7x6_tag", tg, 4'd5);
    check_eq("mul7x6_flags", f, 4'b0000);
    check_eq("mul7x6_lat", lat, 33);

    // MULH -2*3 -> high half all ones
    run_op("mulh_neg", 2'b01, 32'hFFFF_FFFE, 32'd3, 4'd1, 0, r, tg, f, lat);
    check_eq("mulh_neg_res", r, 32'hFFFF_FFFF);
    check_eq("mulh_neg_flags", f, 4'b1000);

    // MULH -1*-1 = 1 -> high half zero
    run_op("mulh_m1m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 0, r, tg, f, lat);
    check_eq("mulh_m1m1_res", r, 32'h0);
    check_eq("mulh_m1m1_flags", f, 4'b0100);

    // MULH 0x40000000*4 = 2^32 -> high half 1
    run_op("mulh_pos", 2'b01, 32'h4000_0000, 32'd4, 4'd2, 0, r, tg, f, lat);
    check_eq("mulh_pos_res", r, 32'h1);

    // MUL 0x10000*0x10000 = 2^32 -> low half 0, Z and C
    run_op("mul_ovf", 2'b00, 32'h0001_0000, 32'h0001_0000, 4'd6, 0, r, tg, f, lat);
    check_eq("mul_ovf_res", r, 32'h0);
    check_eq("mul_ovf_flags", f, 4'b0110);

    // DIVU / REMU 100/7
    run_op("divu", 2'b10, 32'd100, 32'd7, 4'd7, 0, r, tg, f, lat);
    check_eq("divu_res", r, 32'd14);
    check_eq("divu_lat", lat, 33);
    check_eq("divu_flags", f, 4'b0000);
    run_op("remu", 2'b11, 32'd100, 32'd7, 4'd8, 0, r, tg, f, lat);
    check_eq("remu_res", r, 32'd2);
    check_eq("remu_lat", lat, 33);

    // Large remainder: 0xFFFFFFFF % 0x80000001
    run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 4'd8, 0, r, tg, f, lat);
    check_eq("remu_big_res", r, 32'h7FFF_FFFE);
    run_op("divu_big", 2'b10, 32'hFFFF_FFFF, 32'd1, 4'd8, 0, r, tg, f, lat);
    check_eq("divu_big_res", r, 32'hFFFF_FFFF);
    check_eq("divu_big_flags", f, 4'b1000);

    // Divide by zero
    run_op("divz", 2'b10, 32'd5, 32'd0, 4'd9, 0, r, tg, f, lat);
    check_eq("divz_res", r, 32'hFFFF_FFFF);
    check_eq("divz_flags", f, 4'b1010);
    check_eq("divz_lat", lat, 1);
    run_op("remz", 2'b11, 32'd5, 32'd0, 4'd9, 0, r, tg, f, lat);
    check_eq("remz_res", r, 32'd5);
    check_eq("remz_flags", f, 4'b0010);
    check_eq("remz_lat", lat, 1);

    // Back-pressure: hold 10 cycles
    run_op("hold", 2'b00, 32'd3, 32'd5, 4'hA, 10, r, tg, f, lat);
    check_eq("hold_res", r, 32'd15);
    check_eq("hold_tag", tg, 4'hA);

    // Abort with start_valid in IDLE: nothing accepted
    start_valid = 1'b1; abort = 1'b1; mode = 2'b00; op_a = 32'd2; op_b = 32'd2;
    @(negedge clk);
    start_valid = 1'b0; abort = 1'b0;
    check_eq("abort_idle_busy", busy, 1'b0);

    // Abort at RUN edge 10
    start_valid = 1'b1; mode = 2'b00; op_a = 32'd9; op_b = 32'd9; tag_in = 4'h4;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_run_busy", busy, 1'b0);
    check_eq("abort_run_ready", start_ready, 1'b1);
    never = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || busy !== 1'b0) never = 1'b0;
    end
    check_eq("abort_no_result", never, 1'b1);

    // Asynchronous reset mid-RUN
    start_valid = 1'b1; mode = 2'b10; op_a = 32'd50; op_b = 32'd3; tag_in = 4'hC;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_ready", start_ready, 1'b1);
    check_eq("arst_result", result, 32'h0);
    check_eq("arst_tag_flags", {tag_out, flags}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    never = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid !== 1'b0) never = 1'b0;
    end
    check_eq("arst_no_result", never, 1'b1);

    // STEPS=4 instance
    run_op4("s4_mul", 2'b00, 32'd7, 32'd6, r, lat);
    check_eq("s4_mul_res", r, 32'd42);
    check_eq("s4_mul_lat", lat, 9);
    run_op4("s4_divu", 2'b10, 32'd100, 32'd7, r, lat);
    check_eq("s4_divu_res", r, 32'd14);
    check_eq("s4_divu_lat", lat, 9);
    run_op4("s4_mulh", 2'b01, 32'hFFFF_FFFE, 32'd3, r, lat);
    check_eq("s4_mulh_res", r, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
